// File: rtl/sprite_pixel_compositor.sv
// sprite_pixel_compositor: sprite ROM address generation, direction/animation select and 3-stage RGB compositing
// Ports:
//   Clk, Reset                        clock, synchronous active-high reset
//   frame_start                       1-cycle pulse at start of vertical blank
//   pixel_valid, DrawX, DrawY         current pixel and its visibility
//   pac_x/pac_y, pac_dir              Pac-Man top-left and heading (0 left, 1 down, 2 right, 3 up)
//   red/blue/green_x/_y, ghost_en     ghost top-left corners and visibility ([0] red, [1] blue, [2] green)
//   bg_rgb                            background colour aligned with DrawX/DrawY
//   *_read_address                    registered ROM addresses (0 when the sprite is not hit)
//   direction                         Pac-Man ROM select, constant for a whole frame
//   *_data_out                        ROM pixels, one cycle after the address
//   rgb_out, rgb_valid                composited pixel, 3 cycles after DrawX/DrawY
module sprite_pixel_compositor #(
  parameter int          SPRITE_W    = 26,
  parameter int          ANIM_FRAMES = 8,
  parameter logic [23:0] TRANSPARENT = 24'h000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        pixel_valid,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  pac_x,
  input  logic [9:0]  pac_y,
  input  logic [1:0]  pac_dir,
  input  logic [9:0]  red_x,
  input  logic [9:0]  red_y,
  input  logic [9:0]  blue_x,
  input  logic [9:0]  blue_y,
  input  logic [9:0]  green_x,
  input  logic [9:0]  green_y,
  input  logic [2:0]  ghost_en,
  input  logic [23:0] bg_rgb,
  output logic [9:0]  pac_man_cut_read_address,
  output logic [9:0]  pac_man_full_read_address_special,
  output logic [2:0]  direction,
  output logic [9:0]  red_evil_read_address,
  output logic [9:0]  blue_evil_read_address,
  output logic [9:0]  green_evil_read_address,
  input  logic [23:0] pac_man_cut_data_out,
  input  logic [23:0] red_evil_data_out,
  input  logic [23:0] blue_evil_data_out,
  input  logic [23:0] green_evil_data_out,
  output logic [23:0] rgb_out,
  output logic        rgb_valid
);
  localparam int CW = ANIM_FRAMES > 1 ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [9:0] W = 10'(SPRITE_W);
  // 11-bit compare so a sprite near coordinate 1023 does not wrap its right/bottom edge
  function automatic logic in_span(input logic [9:0] p, input logic [9:0] s);
    return {1'b0, p} >= {1'b0, s} && {1'b0, p} < {1'b0, s} + {1'b0, W};
  endfunction
  function automatic logic [9:0] lin(input logic [9:0] dx, input logic [9:0] dy);
    return dy * W + dx;
  endfunction
  logic [9:0] pac_dx, pac_dy, red_dx, red_dy, blue_dx, blue_dy, green_dx, green_dy;
  logic pac_hit, red_hit, blue_hit, green_hit;
  assign pac_dx   = DrawX - pac_x;
  assign pac_dy   = DrawY - pac_y;
  assign red_dx   = DrawX - red_x;
  assign red_dy   = DrawY - red_y;
  assign blue_dx  = DrawX - blue_x;
  assign blue_dy  = DrawY - blue_y;
  assign green_dx = DrawX - green_x;
  assign green_dy = DrawY - green_y;
  assign pac_hit   = pixel_valid && in_span(DrawX, pac_x) && in_span(DrawY, pac_y);
  assign red_hit   = pixel_valid && ghost_en[0] && in_span(DrawX, red_x) && in_span(DrawY, red_y);
  assign blue_hit  = pixel_valid && ghost_en[1] && in_span(DrawX, blue_x) && in_span(DrawY, blue_y);
  assign green_hit = pixel_valid && ghost_en[2] && in_span(DrawX, green_x) && in_span(DrawY, green_y);
  // hit flags, background and valid travel alongside the ROM access so stage 3 sees them with the data
  logic [3:0]  hit1, hit2;
  logic [23:0] bg1, bg2, comp;
  logic        v1, v2;
  assign comp = hit2[0] && pac_man_cut_data_out != TRANSPARENT ? pac_man_cut_data_out :
                hit2[1] && red_evil_data_out    != TRANSPARENT ? red_evil_data_out    :
                hit2[2] && blue_evil_data_out   != TRANSPARENT ? blue_evil_data_out   :
                hit2[3] && green_evil_data_out  != TRANSPARENT ? green_evil_data_out  : bg2;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pac_man_cut_read_address          <= '0;
      pac_man_full_read_address_special <= '0;
      red_evil_read_address             <= '0;
      blue_evil_read_address            <= '0;
      green_evil_read_address           <= '0;
      hit1      <= '0;
      hit2      <= '0;
      bg1       <= '0;
      bg2       <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      rgb_valid <= 1'b0;
      rgb_out   <= '0;
    end else begin
      pac_man_cut_read_address          <= pac_hit ? lin(pac_dx, pac_dy) : '0;
      pac_man_full_read_address_special <= pac_hit ? lin(W - 10'd1 - pac_dx, pac_dy) : '0;
      red_evil_read_address             <= red_hit ? lin(red_dx, red_dy) : '0;
      blue_evil_read_address            <= blue_hit ? lin(blue_dx, blue_dy) : '0;
      green_evil_read_address           <= green_hit ? lin(green_dx, green_dy) : '0;
      hit1      <= {green_hit, blue_hit, red_hit, pac_hit};
      hit2      <= hit1;
      bg1       <= bg_rgb;
      bg2       <= bg1;
      v1        <= pixel_valid;
      v2        <= v1;
      rgb_valid <= v2;
      rgb_out   <= v2 ? comp : '0;
    end
  end
  // mouth toggles every ANIM_FRAMES frame_start pulses; closed mouth uses the full-circle ROM
  logic [CW-1:0] anim_cnt;
  logic          mouth_open, wrap, mouth_next;
  assign wrap       = anim_cnt == CW'(ANIM_FRAMES - 1);
  assign mouth_next = mouth_open ^ wrap;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      anim_cnt   <= '0;
      mouth_open <= 1'b0;
      direction  <= 3'b100;
    end else if (frame_start) begin
      anim_cnt   <= wrap ? '0 : anim_cnt + 1'b1;
      mouth_open <= mouth_next;
      direction  <= mouth_next ? {1'b0, pac_dir} : 3'b100;
    end
  end
endmodule
